// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: writeback scheduler and hazard scoreboard for the
// single write port of the RV32I register file.
// - Arbitrates ALU and LSU results onto one registered write port
//   (LSU first; the ALU gets one forced grant after MAX_WAIT losses).
// - Keeps one busy bit per architectural register.
// - Stalls issue on RAW (rs1/rs2) and WAW (rd) hazards against busy registers.
// Optional feature macro: REGFILE_WB_BYPASS_EN
//   defined   : a register being cleared by this cycle's grant is not a hazard
//   undefined : the raw busy bit is used, so issue stalls through the clear cycle
module regfile_wb_sched #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_iss_valid,
  input  logic [ADDR_W-1:0] i_iss_rs1,
  input  logic [ADDR_W-1:0] i_iss_rs2,
  input  logic [ADDR_W-1:0] i_iss_rd,
  output logic              o_iss_stall,
  input  logic              i_alu_valid,
  input  logic [ADDR_W-1:0] i_alu_rd,
  input  logic [DATA_W-1:0] i_alu_data,
  output logic              o_alu_ready,
  input  logic              i_lsu_valid,
  input  logic [ADDR_W-1:0] i_lsu_rd,
  input  logic [DATA_W-1:0] i_lsu_data,
  output logic              o_lsu_ready,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [DATA_W-1:0] o_rd_val,
  output logic              o_wenable
);

  localparam int          NREG       = 1 << ADDR_W;
  localparam logic [3:0]  MAX_WAIT_C = 4'(MAX_WAIT);

  logic [NREG-1:0]   busy_q, busy_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] val_q;

  logic              alu_prio;
  logic              gnt_alu, gnt_lsu, gnt_valid;
  logic [ADDR_W-1:0] gnt_rd;
  logic [DATA_W-1:0] gnt_data;
  logic              iss_accept;

  // Arbitration: LSU wins by default; a starved ALU takes one grant.
  always_comb begin
    alu_prio  = i_alu_valid && (wait_cnt_q == MAX_WAIT_C);
    gnt_alu   = i_alu_valid && (alu_prio || !i_lsu_valid);
    gnt_lsu   = i_lsu_valid && !gnt_alu;
    gnt_valid = gnt_alu || gnt_lsu;
    gnt_rd    = gnt_alu ? i_alu_rd   : i_lsu_rd;
    gnt_data  = gnt_alu ? i_alu_data : i_lsu_data;
  end

  assign o_alu_ready = gnt_alu;
  assign o_lsu_ready = gnt_lsu;

  // Hazard on register r: busy, not x0, and (with bypass) not being
  // written back by this cycle's grant.
  function automatic logic hz(input logic [ADDR_W-1:0] r);
    logic h;
    h = (r != '0) && busy_q[r];
`ifdef REGFILE_WB_BYPASS_EN
    if (gnt_valid && (gnt_rd == r)) h = 1'b0;
`else
    h = h;
`endif
    return h;
  endfunction

  // Issue stall: RAW on either source, WAW on the destination.
  always_comb begin
    o_iss_stall = i_iss_valid && (hz(i_iss_rs1) || hz(i_iss_rs2) || hz(i_iss_rd));
    iss_accept  = i_iss_valid && !o_iss_stall && (i_iss_rd != '0);
  end

  // Scoreboard next state: clear the granted rd, then set the issued rd so
  // a same-cycle set overrides the clear; x0 is never marked busy.
  always_comb begin
    busy_d = busy_q;
    if (gnt_valid) busy_d[gnt_rd] = 1'b0;
    if (iss_accept) busy_d[i_iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // ALU starvation counter: counts losses, clears on grant or idle ALU.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!i_alu_valid || gnt_alu) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  // A grant to rd=0 is consumed without producing a write.
  assign wen_d = gnt_valid && (gnt_rd != '0);

  // State registers; the write port holds its last address/data when idle.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q     <= '0;
      wait_cnt_q <= '0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      val_q      <= '0;
    end else begin
      busy_q     <= busy_d;
      wait_cnt_q <= wait_cnt_d;
      wen_q      <= wen_d;
      if (wen_d) begin
        addr_q <= gnt_rd;
        val_q  <= gnt_data;
      end
    end
  end

  assign o_wenable = wen_q;
  assign o_rd_addr = addr_q;
  assign o_rd_val  = val_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: a vector table for single-cycle
// behaviour plus hand-written sequences for starvation and async reset.
module tb_regfile_wb_sched;

`ifdef REGFILE_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_iss_valid;
  logic [4:0]  i_iss_rs1, i_iss_rs2, i_iss_rd;
  logic        o_iss_stall;
  logic        i_alu_valid;
  logic [4:0]  i_alu_rd;
  logic [31:0] i_alu_data;
  logic        o_alu_ready;
  logic        i_lsu_valid;
  logic [4:0]  i_lsu_rd;
  logic [31:0] i_lsu_data;
  logic        o_lsu_ready;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_val;
  logic        o_wenable;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_wb_sched #(.ADDR_W(5), .DATA_W(32), .MAX_WAIT(3)) dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_iss_valid(i_iss_valid),
    .i_iss_rs1  (i_iss_rs1),
    .i_iss_rs2  (i_iss_rs2),
    .i_iss_rd   (i_iss_rd),
    .o_iss_stall(o_iss_stall),
    .i_alu_valid(i_alu_valid),
    .i_alu_rd   (i_alu_rd),
    .i_alu_data (i_alu_data),
    .o_alu_ready(o_alu_ready),
    .i_lsu_valid(i_lsu_valid),
    .i_lsu_rd   (i_lsu_rd),
    .i_lsu_data (i_lsu_data),
    .o_lsu_ready(o_lsu_ready),
    .o_rd_addr  (o_rd_addr),
    .o_rd_val   (o_rd_val),
    .o_wenable  (o_wenable)
  );

  typedef struct {
    logic        iv;
    logic [4:0]  rs1, rs2, rd;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        e_stall, e_ar, e_lr, e_wen;
    logic [4:0]  e_addr;
    logic [31:0] e_val;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(
    input logic iv, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
    input logic av, input logic [4:0] ard, input logic [31:0] adat,
    input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
    input logic e_stall, input logic e_ar, input logic e_lr,
    input logic e_wen, input logic [4:0] e_addr, input logic [31:0] e_val);
    vec_t v;
    v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.av = av; v.ard = ard; v.adat = adat;
    v.lv = lv; v.lrd = lrd; v.ldat = ldat;
    v.e_stall = e_stall; v.e_ar = e_ar; v.e_lr = e_lr;
    v.e_wen = e_wen; v.e_addr = e_addr; v.e_val = e_val;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic av, input logic [4:0] ard,
                       input logic [31:0] adat, input logic lv, input logic [4:0] lrd,
                       input logic [31:0] ldat);
    i_iss_valid = iv; i_iss_rs1 = rs1; i_iss_rs2 = rs2; i_iss_rd = rd;
    i_alu_valid = av; i_alu_rd = ard; i_alu_data = adat;
    i_lsu_valid = lv; i_lsu_rd = lrd; i_lsu_data = ldat;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Drive just after the rising edge, sample at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // table: stall, alu_ready, lsu_ready, then write port state left by the previous row
    //              iv rs1 rs2 rd  av ard adat          lv lrd ldat         stall     ar lr wen addr val
    vecs[0]  = mk(1, 0,  0,  5,  0, 0,  0,            0, 0,  0,           0,        0, 0, 0, 0,  32'h0);
    vecs[1]  = mk(1, 5,  0,  0,  0, 0,  0,            0, 0,  0,           1,        0, 0, 0, 0,  32'h0);
    vecs[2]  = mk(1, 5,  0,  0,  1, 5,  32'h1234,     0, 0,  0,           ~BYP,     1, 0, 0, 0,  32'h0);
    vecs[3]  = mk(1, 5,  0,  0,  0, 0,  0,            0, 0,  0,           0,        0, 0, 1, 5,  32'h1234);
    vecs[4]  = mk(0, 0,  0,  0,  1, 3,  32'h33,       1, 4,  32'h44,      0,        0, 1, 0, 5,  32'h1234);
    vecs[5]  = mk(0, 0,  0,  0,  1, 3,  32'h33,       0, 0,  0,           0,        1, 0, 1, 4,  32'h44);
    vecs[6]  = mk(0, 0,  0,  0,  0, 0,  0,            0, 0,  0,           0,        0, 0, 1, 3,  32'h33);
    vecs[7]  = mk(1, 0,  0,  0,  1, 0,  32'hdead,     0, 0,  0,           0,        1, 0, 0, 3,  32'h33);
    vecs[8]  = mk(1, 0,  0,  0,  0, 0,  0,            0, 0,  0,           0,        0, 0, 0, 3,  32'h33);
    vecs[9]  = mk(0, 0,  0,  0,  0, 0,  0,            1, 10, 32'haa,      0,        0, 1, 0, 3,  32'h33);
    vecs[10] = mk(1, 10, 0,  0,  0, 0,  0,            0, 0,  0,           0,        0, 0, 1, 10, 32'haa);
    vecs[11] = mk(1, 0,  0,  12, 0, 0,  0,            0, 0,  0,           0,        0, 0, 0, 10, 32'haa);
    vecs[12] = mk(1, 1,  2,  12, 0, 0,  0,            0, 0,  0,           1,        0, 0, 0, 10, 32'haa);
    vecs[13] = mk(1, 0,  12, 0,  0, 0,  0,            1, 12, 32'hc,       ~BYP,     0, 1, 0, 10, 32'haa);
    vecs[14] = mk(1, 0,  12, 0,  0, 0,  0,            0, 0,  0,           0,        0, 0, 1, 12, 32'hc);

    // Reset held with every valid asserted: no write may appear.
    i_rst_n = 1'b0;
    drive(1, 1, 2, 5, 1, 3, 32'h1111, 1, 4, 32'h2222);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      chk("rst_wen", {31'b0, o_wenable}, 0);
    end
    idle();
    #1;
    i_rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("rst_alu_ready", {31'b0, o_alu_ready}, 0);
    chk("rst_lsu_ready", {31'b0, o_lsu_ready}, 0);
    chk("rst_stall", {31'b0, o_iss_stall}, 0);
    chk("rst_wen_after", {31'b0, o_wenable}, 0);
    chk("rst_addr", {27'b0, o_rd_addr}, 0);
    chk("rst_val", o_rd_val, 0);
    // Every busy bit clear: no source register stalls.
    for (int r = 1; r < 32; r++) begin
      next_cycle();
      drive(1, 5'(r), 5'(r), 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("rst_busy_clear", {31'b0, o_iss_stall}, 0);
    end
    next_cycle();
    idle();

    // Table-driven single-cycle behaviour.
    for (int i = 0; i < 15; i++) begin
      next_cycle();
      drive(vecs[i].iv, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].av, vecs[i].ard,
            vecs[i].adat, vecs[i].lv, vecs[i].lrd, vecs[i].ldat);
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), {31'b0, o_iss_stall}, {31'b0, vecs[i].e_stall});
      chk($sformatf("v%0d_alu_ready", i), {31'b0, o_alu_ready}, {31'b0, vecs[i].e_ar});
      chk($sformatf("v%0d_lsu_ready", i), {31'b0, o_lsu_ready}, {31'b0, vecs[i].e_lr});
      chk($sformatf("v%0d_wen", i), {31'b0, o_wenable}, {31'b0, vecs[i].e_wen});
      chk($sformatf("v%0d_addr", i), {27'b0, o_rd_addr}, {27'b0, vecs[i].e_addr});
      chk($sformatf("v%0d_val", i), o_rd_val, vecs[i].e_val);
    end

    // ALU starvation: three losses to a continuous LSU, then one forced grant.
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      if (k < 4)       drive(0, 0, 0, 0, 1, 21, 32'h21, 1, 20, 32'h200);
      else if (k == 4) drive(0, 0, 0, 0, 1, 22, 32'h22, 1, 20, 32'h200);
      else             idle();
      @(negedge clk);
      if (k < 3) begin
        chk($sformatf("starve%0d_alu_ready", k), {31'b0, o_alu_ready}, 0);
        chk($sformatf("starve%0d_lsu_ready", k), {31'b0, o_lsu_ready}, 1);
      end else if (k == 3) begin
        chk("starve3_alu_ready", {31'b0, o_alu_ready}, 1);
        chk("starve3_lsu_ready", {31'b0, o_lsu_ready}, 0);
      end else if (k == 4) begin
        // counter restarted: LSU wins again
        chk("starve4_alu_ready", {31'b0, o_alu_ready}, 0);
        chk("starve4_lsu_ready", {31'b0, o_lsu_ready}, 1);
        chk("starve4_addr", {27'b0, o_rd_addr}, 21);
        chk("starve4_val", o_rd_val, 32'h21);
      end else begin
        chk("starve5_addr", {27'b0, o_rd_addr}, 20);
        chk("starve5_val", o_rd_val, 32'h200);
      end
      if (k >= 1) chk($sformatf("starve%0d_wen", k), {31'b0, o_wenable}, 1);
    end

    // Set beats clear on x7, then async reset during the pending write.
    next_cycle();
    drive(1, 0, 0, 7, 1, 7, 32'h77, 0, 0, 0);
    @(negedge clk);
    chk("x7_alu_ready", {31'b0, o_alu_ready}, 1);
    chk("x7_issue_stall", {31'b0, o_iss_stall}, 0);
    next_cycle();
    drive(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("x7_busy_kept", {31'b0, o_iss_stall}, 1);
    chk("x7_wen", {31'b0, o_wenable}, 1);
    chk("x7_addr", {27'b0, o_rd_addr}, 7);
    chk("x7_val", o_rd_val, 32'h77);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_wen", {31'b0, o_wenable}, 0);
    chk("midrst_addr", {27'b0, o_rd_addr}, 0);
    chk("midrst_stall", {31'b0, o_iss_stall}, 0);
    @(negedge clk);
    i_rst_n = 1'b1;
    next_cycle();
    drive(1, 7, 7, 7, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("postrst_busy7", {31'b0, o_iss_stall}, 0);
    chk("postrst_wen", {31'b0, o_wenable}, 0);
    next_cycle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
